// File: rtl/residual_relu_sfu.sv
// Residual-add / ReLU / saturate unit: streams rows from the output SRAM and the
// residual SRAM, combines them per channel and hands rows out through a 2-entry FIFO.

module residual_relu_sfu #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int RES_BW  = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW:0]            cfg_len,
  input  logic                   cfg_res_en,
  input  logic                   cfg_relu_en,
  output logic                   op_cen,
  output logic [AW-1:0]          op_addr,
  input  logic [COL*PSUM_BW-1:0] op_q,
  output logic                   res_cen,
  output logic [AW-1:0]          res_addr,
  input  logic [COL*RES_BW-1:0]  res_q,
  output logic [COL*PSUM_BW-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int SW = ((PSUM_BW > RES_BW) ? PSUM_BW : RES_BW) + 1;
  localparam int RW = COL * PSUM_BW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};

  // One channel: widen, optionally add residual, then ReLU or saturate to PSUM_BW.
  function automatic logic [PSUM_BW-1:0] sfu_lane(
    input logic signed [PSUM_BW-1:0] psum,
    input logic signed [RES_BW-1:0]  res,
    input logic                      res_en,
    input logic                      relu_en
  );
    logic signed [SW-1:0] res_ext;
    logic signed [SW-1:0] sum;
    logic [PSUM_BW-1:0]   lane;
    res_ext = res_en ? SW'(res) : {SW{1'b0}};
    sum     = SW'(psum) + res_ext;
    if (relu_en && sum[SW-1]) begin
      lane = {PSUM_BW{1'b0}};
    end else if (sum > SAT_MAX) begin
      lane = SAT_MAX[PSUM_BW-1:0];
    end else if (sum < SAT_MIN) begin
      lane = SAT_MIN[PSUM_BW-1:0];
    end else begin
      lane = sum[PSUM_BW-1:0];
    end
    return lane;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW:0]   row_q, row_d;
  logic [AW:0]   len_q, len_d;
  logic          res_en_q, res_en_d;
  logic          relu_en_q, relu_en_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] mem_q [2];
  logic [RW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic [2:0]    occ_s;
  logic [RW-1:0] row_res_s;

  // Per-channel result of the row whose SRAM data is on op_q/res_q this cycle.
  always_comb begin
    row_res_s = {RW{1'b0}};
    for (int c = 0; c < COL; c++) begin
      row_res_s[c*PSUM_BW +: PSUM_BW] = sfu_lane(op_q[c*PSUM_BW +: PSUM_BW],
                                                  res_q[c*RES_BW +: RES_BW],
                                                  res_en_q, relu_en_q);
    end
  end

  // Sequencing, read issue and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    len_d     = len_q;
    res_en_d  = res_en_q;
    relu_en_d = relu_en_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    pop_s  = (count_q != 2'd0) && out_ready;
    push_s = inflight_q;
    // A row being popped this cycle frees its slot in time for a read issued now.
    occ_s   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    issue_s = (state_q == S_READ) && (row_q < len_q) && (occ_s < 3'd2);

    count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};
    inflight_d = issue_s;
    addr_d     = issue_s ? row_q[AW-1:0] : addr_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = row_res_s;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          res_en_d  = cfg_res_en;
          relu_en_d = cfg_relu_en;
          row_d     = {(AW+1){1'b0}};
          if (cfg_len != {(AW+1){1'b0}}) begin
            state_d = S_READ;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (issue_s) begin
          row_d = row_q + (AW+1)'(1);
          if (row_d == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if ((count_d == 2'd0) && !inflight_d) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= {(AW+1){1'b0}};
      len_q      <= {(AW+1){1'b0}};
      res_en_q   <= 1'b0;
      relu_en_q  <= 1'b0;
      inflight_q <= 1'b0;
      addr_q     <= {AW{1'b0}};
      mem_q[0]   <= {RW{1'b0}};
      mem_q[1]   <= {RW{1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      len_q      <= len_d;
      res_en_q   <= res_en_d;
      relu_en_q  <= relu_en_d;
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Enables follow the issue decision directly so a pop can be refilled in the same cycle.
  assign op_cen    = ~issue_s;
  assign res_cen   = ~issue_s;
  assign op_addr   = issue_s ? row_q[AW-1:0] : addr_q;
  assign res_addr  = issue_s ? row_q[AW-1:0] : addr_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_residual_relu_sfu.sv
// Randomized bench for residual_relu_sfu: SRAM models plus an arithmetic reference
// model of each output row, checked by a negedge monitor and directed timing checks.

module tb_residual_relu_sfu;

  localparam int COL   = 8;
  localparam int PB    = 16;
  localparam int RB    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RW    = COL * PB;
  localparam int PMAX  = 32767;
  localparam int PMIN  = -32768;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start;
  logic [AW:0]     cfg_len;
  logic            cfg_res_en;
  logic            cfg_relu_en;
  logic            op_cen;
  logic [AW-1:0]   op_addr;
  logic [RW-1:0]   op_q;
  logic            res_cen;
  logic [AW-1:0]   res_addr;
  logic [COL*RB-1:0] res_q;
  logic [RW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  logic [RW-1:0]     op_mem  [DEPTH];
  logic [COL*RB-1:0] res_mem [DEPTH];

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q [$];
  int exp_addr = 0;
  int issued   = 0;
  int accepted = 0;
  int pass_len = 0;
  logic [AW-1:0] last_addr = '0;
  logic stalled_prev = 1'b0;
  logic [RW-1:0] prev_data = '0;
  bit bp_mode = 1'b0;

  residual_relu_sfu #(.COL(COL), .PSUM_BW(PB), .RES_BW(RB), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .cfg_res_en(cfg_res_en), .cfg_relu_en(cfg_relu_en),
    .op_cen(op_cen), .op_addr(op_addr), .op_q(op_q),
    .res_cen(res_cen), .res_addr(res_addr), .res_q(res_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!op_cen) op_q <= op_mem[op_addr];
    if (!res_cen) res_q <= res_mem[res_addr];
  end

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input int a, input bit re, input bit rl);
    logic [RW-1:0] r;
    int p, q, s;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      p = $signed(op_mem[a][c*PB +: PB]);
      q = $signed(res_mem[a][c*RB +: RB]);
      s = p + (re ? q : 0);
      if (rl && s < 0) s = 0;
      else if (s > PMAX) s = PMAX;
      else if (s < PMIN) s = PMIN;
      r[c*PB +: PB] = s[PB-1:0];
    end
    return r;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < DEPTH; i++) begin
      for (int c = 0; c < COL; c++) begin
        op_mem[i][c*PB +: PB]  = 16'($urandom);
        res_mem[i][c*RB +: RB] = 16'($urandom);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_start(input int len, input bit re, input bit rl);
    exp_q.delete();
    for (int a = 0; a < len; a++) exp_q.push_back(exp_row(a, re, rl));
    exp_addr = 0;
    issued   = 0;
    accepted = 0;
    pass_len = len;
    cfg_len     = 5'(len);
    cfg_res_en  = re;
    cfg_relu_en = rl;
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    cfg_len     = 5'($urandom_range(0, 16));
    cfg_res_en  = 1'($urandom);
    cfg_relu_en = 1'($urandom);
    out_ready   = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = done;
    end
    chk("done_seen", seen, 1'b1);
    step();
    chk("idle_after", busy, 1'b0);
    chk("done_pulse", done, 1'b0);
  endtask

  // Monitor: read addresses, address hold, row order/content, stall stability, done.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled_prev = 1'b0;
      end else begin
        if (!op_cen) begin
          chk("rd_in_range", issued < pass_len, 1'b1);
          chk("rd_addr", op_addr, exp_addr);
          chk("res_cen_lo", res_cen, 1'b0);
          chk("res_addr", res_addr, exp_addr);
          exp_addr++;
          issued++;
          last_addr = op_addr;
        end else begin
          chk("addr_hold", op_addr, last_addr);
          chk("res_cen_hi", res_cen, 1'b1);
          chk("res_addr_hold", res_addr, last_addr);
        end
        chk("outstanding", (issued - accepted) <= 3, 1'b1);
        if (out_valid && stalled_prev) chk("stall_hold", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_row", 1'b1, 1'b0);
          else chk("row", out_data, exp_q.pop_front());
          accepted++;
        end
        stalled_prev = out_valid && !out_ready;
        prev_data = out_data;
        if (done) begin
          chk("done_rows", accepted, pass_len);
          chk("done_empty", exp_q.size(), 0);
        end
      end
    end
  end

  initial begin
    int n;
    int len;
    start = 1'b0; cfg_len = '0; cfg_res_en = 1'b0; cfg_relu_en = 1'b0; out_ready = 1'b1;
    op_q = '0; res_q = '0;
    fill_rand();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_cen", op_cen, 1'b1);
    chk("rst_res_cen", res_cen, 1'b1);
    chk("rst_op_addr", op_addr, 4'd0);
    chk("rst_res_addr", res_addr, 4'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // Basic pass with exact timing, start on the first edge after reset release.
    reset = 1'b1;
    fill_rand();
    op_mem[0][15:0] = 16'hFFFB; res_mem[0][15:0] = 16'd3;
    op_mem[1][15:0] = 16'd100;  res_mem[1][15:0] = 16'd20;
    do_start(16, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      chk("b_valid", out_valid, (k >= 2) && (k <= 17));
      chk("b_done", done, k == 18);
      chk("b_busy", busy, k <= 18);
      if (k == 2) chk("b_relu_ch0", out_data[15:0], 16'd0);
      if (k == 3) chk("b_add_ch0", out_data[15:0], 16'd120);
    end
    chk("b_rows", accepted, 16);

    // Saturation, then the same data with ReLU.
    fill_rand();
    for (int c = 0; c < COL; c++) begin
      op_mem[0][c*PB +: PB] = 16'(32000);  res_mem[0][c*RB +: RB] = 16'(1000);
      op_mem[1][c*PB +: PB] = 16'(-32000); res_mem[1][c*RB +: RB] = 16'(-1000);
    end
    do_start(2, 1'b1, 1'b0);
    step(); step();
    chk("s_pos", out_data[15:0], 16'h7FFF);
    step();
    chk("s_neg", out_data[15:0], 16'h8000);
    wait_done(20);
    do_start(2, 1'b1, 1'b1);
    step(); step(); step();
    chk("s_neg_relu", out_data[15:0], 16'h0000);
    wait_done(20);

    // Random backpressure over 16 rows.
    fill_rand();
    bp_mode = 1'b1;
    do_start(16, 1'b1, 1'($urandom));
    wait_done(400);
    chk("bp_rows", accepted, 16);
    bp_mode = 1'b0;

    // Edge lengths.
    do_start(0, 1'b1, 1'b1);
    chk("l0_done", done, 1'b1);
    chk("l0_busy", busy, 1'b1);
    chk("l0_cen", op_cen, 1'b1);
    step();
    chk("l0_done_end", done, 1'b0);
    chk("l0_idle", busy, 1'b0);
    step();
    chk("l0_noreads", issued, 0);
    fill_rand();
    do_start(1, 1'b1, 1'b0);
    wait_done(20);
    chk("l1_reads", issued, 1);
    chk("l1_rows", accepted, 1);

    // Reset in the middle of a pass, then a fresh short pass.
    fill_rand();
    do_start(16, 1'b1, 1'b1);
    n = 0;
    while (accepted < 5 && n < 50) begin step(); n++; end
    chk("r_reach5", accepted >= 5, 1'b1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    last_addr = '0;
    chk("r_op_cen", op_cen, 1'b1);
    chk("r_res_cen", res_cen, 1'b1);
    chk("r_op_addr", op_addr, 4'd0);
    chk("r_res_addr", res_addr, 4'd0);
    chk("r_out_data", out_data, '0);
    chk("r_out_valid", out_valid, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_done", done, 1'b0);
    step();
    chk("r_nodone", done, 1'b0);
    step();
    reset = 1'b1;
    fill_rand();
    do_start(4, 1'b1, 1'b0);
    wait_done(20);
    chk("r_rows", accepted, 4);

    // Residual disabled and start pulsed while busy.
    fill_rand();
    do_start(6, 1'b0, 1'b0);
    step(); step();
    chk("m_noresid", out_data, op_mem[0]);
    step();
    start = 1'b1; cfg_len = 5'd2; cfg_res_en = 1'b1;
    step();
    start = 1'b0;
    wait_done(30);
    chk("m_rows", accepted, 6);
    repeat (3) begin
      step();
      chk("m_idle", busy, 1'b0);
    end

    // Random passes.
    for (int i = 0; i < 4; i++) begin
      fill_rand();
      bp_mode = 1'($urandom);
      len = $urandom_range(1, 16);
      do_start(len, 1'($urandom), 1'($urandom));
      wait_done(300);
      chk("rand_rows", accepted, len);
    end
    bp_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
